// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
// Owner encoding: 0 = instruction cache, 1 = data cache.
package mem_arbiter_pkg;

  localparam int unsigned MemAddressLen   = 32;
  localparam int unsigned IcacheLineWidth = 128;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbIssue   = 2'd1,
    ArbWait    = 2'd2,
    ArbDeliver = 2'd3
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t OwnI = 1'b0;
  localparam owner_t OwnD = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter.
// The slave modport is the arbiter; master is the caches plus the memory model.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = MemAddressLen,
  parameter int unsigned LINE_W = IcacheLineWidth
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_rdy;
  logic [LINE_W-1:0] i_line;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_rdy;
  logic [LINE_W-1:0] d_line;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rdy;

  logic              busy;
  logic              grant_d;

  modport slave (
    input  i_req, i_addr, i_ack, d_req, d_we, d_addr, d_wdata, d_ack, mem_rdata, mem_rdy,
    output i_rdy, i_line, d_rdy, d_line, mem_req, mem_we, mem_addr, mem_wdata, busy, grant_d
  );

  modport master (
    output i_req, i_addr, i_ack, d_req, d_we, d_addr, d_wdata, d_ack, mem_rdata, mem_rdy,
    input  i_rdy, i_line, d_rdy, d_line, mem_req, mem_we, mem_addr, mem_wdata, busy, grant_d
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between the I and D requesters.
// On a tie the requester that did not own the port last wins.
module rr_arbiter2 import mem_arbiter_pkg::*; (
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   gnt_valid,
  output logic   gnt_d
);

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_d     = d_req & (~i_req | (last_owner == OwnI));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the iCache and dCache.
// One transaction at a time: grant, one-cycle command, wait for memory, hand back.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = MemAddressLen,
  parameter int unsigned LINE_W = IcacheLineWidth
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_line_q, i_line_d;
  logic [LINE_W-1:0] d_line_q, d_line_d;
  logic              gnt_valid;
  logic              gnt_d;
  logic              owner_ack;

  rr_arbiter2 u_rr (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_owner (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_d      (gnt_d)
  );

  // Only the current owner's ack counts; the other side's ack is ignored.
  assign owner_ack = (owner_q == OwnD) ? bus.d_ack : bus.i_ack;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;
    unique case (state_q)
      ArbIdle: begin
        if (gnt_valid) begin
          state_d = ArbIssue;
          owner_d = gnt_d;
          if (gnt_d == OwnD) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.i_addr;
            wdata_d = '0;
          end
        end
      end
      ArbIssue: state_d = ArbWait;
      ArbWait: begin
        if (bus.mem_rdy) begin
          state_d = ArbDeliver;
          // Write-backs leave both line registers untouched.
          if (!we_q) begin
            if (owner_q == OwnD) d_line_d = bus.mem_rdata;
            else                 i_line_d = bus.mem_rdata;
          end
        end
      end
      ArbDeliver: begin
        if (owner_ack) begin
          state_d = ArbIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ArbIdle;
      owner_q  <= OwnI;
      last_q   <= OwnD;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
    end
  end

  // Every output is decoded from flops only.
  assign bus.busy      = (state_q != ArbIdle);
  assign bus.mem_req   = (state_q == ArbIssue);
  assign bus.i_rdy     = (state_q == ArbDeliver) && (owner_q == OwnI);
  assign bus.d_rdy     = (state_q == ArbDeliver) && (owner_q == OwnD);
  assign bus.grant_d   = owner_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_line    = i_line_q;
  assign bus.d_line    = d_line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned LW = 64;
  localparam logic [LW-1:0] PatA5 = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic        auto_rdy;
  logic        spur_rdy;
  int unsigned mem_cnt;
  int unsigned n_mem_req = 0;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read data encodes the address; mem_rdy pulses 3 cycles after mem_req.
  assign bus.mem_rdy   = auto_rdy | spur_rdy;
  assign bus.mem_rdata = {32'hDEADBEEF, 20'h0, bus.mem_addr};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cnt  <= 0;
      auto_rdy <= 1'b0;
    end else begin
      auto_rdy <= 1'b0;
      if (bus.mem_req) begin
        mem_cnt <= 3;
      end else if (mem_cnt != 0) begin
        mem_cnt <= mem_cnt - 1;
        if (mem_cnt == 1) auto_rdy <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (bus.mem_req) n_mem_req <= n_mem_req + 1;

  function automatic logic [LW-1:0] exp_line(input logic [AW-1:0] a);
    return {32'hDEADBEEF, 20'h0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    spur_rdy    = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_ack   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.i_rdy !== 1'b0 || bus.d_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b mem_req=%b i_rdy=%b d_rdy=%b, required all 0",
               bus.busy, bus.mem_req, bus.i_rdy, bus.d_rdy);
    end
    checks++;
    if (bus.grant_d !== 1'b0 || bus.i_line !== '0 || bus.d_line !== '0 || bus.mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: grant_d=%b i_line=%h d_line=%h mem_addr=%h, required all 0",
               bus.grant_d, bus.i_line, bus.d_line, bus.mem_addr);
    end
  endtask

  task automatic test_i_fill();
    int unsigned n0;
    bit got, bad_d;
    n0 = n_mem_req;
    bus.i_req  = 1'b1;
    bus.i_addr = 12'h040;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h040) begin
      errors++;
      $display("FAIL ifill_issue: mem_req=%b mem_we=%b mem_addr=%h, required 1 0 040",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    got = 0; bad_d = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (bus.d_rdy) bad_d = 1;
      if (bus.i_rdy) got = 1;
    end
    checks++;
    if (!got || bad_d) begin
      errors++;
      $display("FAIL ifill_rdy: i_rdy_seen=%b d_rdy_seen=%b, required 1 0", got, bad_d);
    end
    checks++;
    if (bus.i_line !== exp_line(12'h040)) begin
      errors++;
      $display("FAIL ifill_line: i_line=%h, required %h", bus.i_line, exp_line(12'h040));
    end
    bus.i_ack = 1'b1;
    bus.i_req = 1'b0;
    tick();
    bus.i_ack = 1'b0;
    checks++;
    if (bus.i_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ifill_done: i_rdy=%b busy=%b, required 0 0", bus.i_rdy, bus.busy);
    end
    checks++;
    if (n_mem_req - n0 != 1) begin
      errors++;
      $display("FAIL ifill_count: mem_req cycles=%0d, required 1", n_mem_req - n0);
    end
  endtask

  task automatic test_d_writeback();
    bit got, unstable;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 12'h100;
    bus.d_wdata = PatA5;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h100 ||
        bus.mem_wdata !== PatA5) begin
      errors++;
      $display("FAIL dwb_issue: mem_req=%b mem_we=%b mem_addr=%h mem_wdata=%h, required 1 1 100 %h",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, PatA5);
    end
    // Changing the request fields after the grant must not reach the memory side.
    bus.d_wdata = '0;
    bus.d_we    = 1'b0;
    got = 0; unstable = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (bus.d_rdy) got = 1;
      else if (bus.mem_we !== 1'b1 || bus.mem_wdata !== PatA5 || bus.mem_addr !== 12'h100)
        unstable = 1;
      if (bus.i_rdy) unstable = 1;
    end
    checks++;
    if (!got || unstable) begin
      errors++;
      $display("FAIL dwb_hold: d_rdy_seen=%b unstable=%b, required 1 0", got, unstable);
    end
    checks++;
    if (bus.d_line !== '0 || bus.grant_d !== 1'b1) begin
      errors++;
      $display("FAIL dwb_line: d_line=%h grant_d=%b, required 0 1", bus.d_line, bus.grant_d);
    end
    bus.d_ack = 1'b1;
    bus.d_req = 1'b0;
    tick();
    bus.d_ack = 1'b0;
    checks++;
    if (bus.d_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dwb_done: d_rdy=%b busy=%b, required 0 0", bus.d_rdy, bus.busy);
    end
  endtask

  task automatic test_spurious();
    bit got;
    spur_rdy = 1'b1;
    tick();
    spur_rdy = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.i_rdy !== 1'b0 || bus.d_rdy !== 1'b0) begin
      errors++;
      $display("FAIL spur_memrdy: busy=%b i_rdy=%b d_rdy=%b, required 0 0 0",
               bus.busy, bus.i_rdy, bus.d_rdy);
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 12'h080;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (bus.i_rdy) got = 1;
    end
    bus.d_ack = 1'b1;
    tick();
    tick();
    bus.d_ack = 1'b0;
    checks++;
    if (!got || bus.i_rdy !== 1'b1 || bus.busy !== 1'b1 || bus.d_rdy !== 1'b0) begin
      errors++;
      $display("FAIL spur_dack: seen=%b i_rdy=%b busy=%b d_rdy=%b, required 1 1 1 0",
               got, bus.i_rdy, bus.busy, bus.d_rdy);
    end
    bus.i_ack = 1'b1;
    bus.i_req = 1'b0;
    tick();
    bus.i_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned n0;
    bit got, overlap, wrong_rdy;
    logic [3:0] order;
    do_reset();
    n0 = n_mem_req;
    order = '0;
    overlap = 0; wrong_rdy = 0;
    bus.i_addr = 12'h040;
    bus.d_addr = 12'h300;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (bus.mem_req) got = 1;
        else tick();
      end
      order[t] = bus.grant_d;
      if (!got) overlap = 1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (bus.mem_req) overlap = 1;
        if (bus.grant_d ? bus.i_rdy : bus.d_rdy) wrong_rdy = 1;
        if (bus.grant_d ? bus.d_rdy : bus.i_rdy) got = 1;
      end
      if (!got) overlap = 1;
      if (bus.grant_d) begin bus.d_ack = 1'b1; bus.d_req = 1'b0; end
      else             begin bus.i_ack = 1'b1; bus.i_req = 1'b0; end
      tick();
      bus.i_ack = 1'b0;
      bus.d_ack = 1'b0;
      if (t < 3) begin
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
      end else begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    tick();
    tick();
    checks++;
    if (order !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_order: grant_d by txn (t3..t0)=%b, required 1010", order);
    end
    checks++;
    if (overlap || wrong_rdy || n_mem_req - n0 != 4) begin
      errors++;
      $display("FAIL b2b_issue: overlap=%b wrong_rdy=%b mem_req cycles=%0d, required 0 0 4",
               overlap, wrong_rdy, n_mem_req - n0);
    end
  endtask

  task automatic test_ack_delay();
    bit got, unstable;
    bus.i_req  = 1'b1;
    bus.i_addr = 12'h0C0;
    tick();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 12'h200;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (bus.i_rdy) got = 1;
    end
    unstable = !got;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.i_rdy !== 1'b1 || bus.i_line !== exp_line(12'h0C0) || bus.mem_req || bus.d_rdy)
        unstable = 1;
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL ackdly_hold: i_rdy=%b i_line=%h, required 1 %h held 5 cycles",
               bus.i_rdy, bus.i_line, exp_line(12'h0C0));
    end
    bus.i_ack = 1'b1;
    bus.i_req = 1'b0;
    tick();
    bus.i_ack = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ackdly_idle: busy=%b mem_req=%b, required 0 0", bus.busy, bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.grant_d !== 1'b1 || bus.mem_addr !== 12'h200) begin
      errors++;
      $display("FAIL ackdly_next: mem_req=%b grant_d=%b mem_addr=%h, required 1 1 200",
               bus.mem_req, bus.grant_d, bus.mem_addr);
    end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (bus.d_rdy) got = 1;
    end
    checks++;
    if (!got || bus.d_line !== exp_line(12'h200)) begin
      errors++;
      $display("FAIL dfill_line: d_rdy_seen=%b d_line=%h, required 1 %h",
               got, bus.d_line, exp_line(12'h200));
    end
    bus.d_ack = 1'b1;
    bus.d_req = 1'b0;
    tick();
    bus.d_ack = 1'b0;
  endtask

  task automatic test_reset_abort();
    bus.i_req  = 1'b1;
    bus.i_addr = 12'h0A0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait: busy=%b mem_req=%b, required 1 0", bus.busy, bus.mem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.i_rdy !== 1'b0 ||
        bus.d_rdy !== 1'b0 || bus.i_line !== '0 || bus.d_line !== '0 || bus.grant_d !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: busy=%b mem_addr=%h i_line=%h d_line=%h, required all 0",
               bus.busy, bus.mem_addr, bus.i_line, bus.d_line);
    end
    bus.i_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b, required 0", bus.busy);
    end
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 12'h300;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.grant_d !== 1'b0 || bus.mem_addr !== 12'h0A0) begin
      errors++;
      $display("FAIL abort_tie: mem_req=%b grant_d=%b mem_addr=%h, required 1 0 0a0",
               bus.mem_req, bus.grant_d, bus.mem_addr);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_d_writeback();
    test_spurious();
    test_back_to_back();
    test_ack_delay();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single main-memory port between the instruction cache (fetch-stage line fills) and the data cache (line fills and write-backs). It accepts level-held requests, grants one requester at a time with round-robin tie-breaking, and issues one memory transaction. It returns the read line with a ready/ack handshake that matches the existing iCache fill protocol. It sits between the caches and the memory model, at processor top level.

## Interface

Parameters:
- ADDR_W, default `MEM_ADDRESS_LEN: memory line address width.
- LINE_W, default `ICACHE_LINE_WIDTH: cache line width in bits (same width for I and D).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- i_req  in  1  iCache line-fill request, level-held.
- i_addr  in  ADDR_W  iCache request line address.
- i_ack  in  1  iCache has filled the line (data_filled_ack).
- i_rdy  out  1  i_line valid for the iCache (mem_data_rdy).
- i_line  out  LINE_W  fill data for the iCache.
- d_req  in  1  dCache request, level-held.
- d_we  in  1  1 = write-back, 0 = fill; sampled with d_req.
- d_addr  in  ADDR_W  dCache line address.
- d_wdata  in  LINE_W  write-back data.
- d_ack  in  1  dCache acknowledges d_rdy.
- d_rdy  out  1  dCache transaction complete; d_line valid when the transaction was a read.
- d_line  out  LINE_W  fill data for the dCache.
- mem_req  out  1  one-cycle memory command strobe.
- mem_we  out  1  command is a write.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  LINE_W  write data.
- mem_rdata  in  LINE_W  memory read data; valid with mem_rdy.
- mem_rdy  in  1  one-cycle completion pulse from memory.
- busy  out  1  state is not IDLE.
- grant_d  out  1  current or last owner: 0 = I, 1 = D.

## Operation

- FSM states: IDLE, ISSUE, WAIT_MEM, DELIVER.
- IDLE:
  - If no request is active, stay in IDLE.
  - If exactly one request is active, grant it.
  - If both are active, grant the requester that is not the last owner (round-robin).
  - On a grant: latch owner, we, addr and wdata; go to ISSUE.
- ISSUE: mem_req=1 for exactly one cycle, with the latched we/addr/wdata on mem_*. Go to WAIT_MEM.
- WAIT_MEM:
  - Hold mem_addr, mem_we and mem_wdata stable.
  - On mem_rdy, capture mem_rdata into the owner's line register (reads only). Go to DELIVER.
- DELIVER:
  - The owner's rdy=1 and its line is held stable.
  - On the owner's ack, go to IDLE and update last owner. rdy drops on the next edge.
- The requester must deassert req no later than the cycle it asserts ack. The arbiter samples req only in IDLE.
- Ignored inputs:
  - mem_rdy outside WAIT_MEM.
  - ack outside DELIVER.
  - ack from the non-owner.
- Request changes while not in IDLE have no effect. The request is re-evaluated in IDLE.
- d_line is not updated on write-backs.
- Reset values:
  - FSM state: IDLE.
  - Last owner: D, so the first tie goes to I.
  - Outputs: all 0, including grant_d=0, i_line=0 and d_line=0.
- Reset mid-transaction aborts the transaction. No rdy is issued; the memory model must be reset together with the arbiter.

## Timing

- A request visible at edge k gives ISSUE at edge k+1 (mem_req high in cycle k+1..k+2).
- With mem_rdy at edge m, rdy is high from edge m+1.
- With ack at edge a, the arbiter is in IDLE at a+1. A new grant can occur at a+1 (ISSUE at a+2).
- Arbiter overhead: 3 cycles per transaction beyond memory latency and ack delay.
- mem_rdy arriving in the same cycle as mem_req is not possible: memory latency is ≥1 cycle after the ISSUE edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure

- header.vh gets:
  - State encodings: ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_DELIVER=2'd3.
  - Owner constants: OWN_I=1'b0, OWN_D=1'b1.
- Sub-module rr_arbiter2: combinational round-robin pick, inputs i_req, d_req, last_owner; outputs gnt_valid, gnt_d. The last-owner register stays in mem_arbiter.
- The FSM and the request/line registers live in mem_arbiter.

## Test plan

- Single I fill: i_req=1, i_addr=0x040; memory returns 0xDEADBEEF_… 3 cycles after mem_req.
  - Expect one mem_req pulse with mem_we=0, mem_addr=0x040.
  - Expect i_rdy high with that line until i_ack, and d_rdy never high.
- D write-back: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xA5…A5.
  - Expect mem_req with mem_we=1 and the data stable until mem_rdy.
  - Expect d_rdy after mem_rdy, and d_line unchanged (0).
- Simultaneous requests from reset: i_req=d_req=1, continuously re-requested.
  - Expect grant order I, D, I, D.
  - Expect exactly one mem_req per transaction and no overlap.
- Ack delay: withhold i_ack for 5 cycles after i_rdy.
  - Expect i_rdy and i_line stable for all 5 cycles.
  - Expect a pending d_req not issued until the cycle after i_ack (ISSUE at a+2).
- Spurious inputs: mem_rdy pulse in IDLE, then d_ack during an I transaction.
  - Expect no state change and no rdy output.
- Reset abort: assert reset low during WAIT_MEM.
  - Expect all outputs 0 immediately (asynchronous).
  - After release, expect IDLE, and a tie then goes to I.
